// File: rtl/cache_mem_pkg.sv
// Shared types for the cache memory responder: FSM states,
// line geometry defaults and the latched request bundle.
package cache_mem_pkg;

   localparam int unsigned LINE_BYTES = 16;
   localparam int unsigned BEAT_IDX_W = $clog2(LINE_BYTES / 4);

   typedef enum logic [2:0] {
      IDLE,
      WAIT,
      RBURST,
      WBURST,
      WACK
   } state_e;

   typedef struct packed {
      logic        we;
      logic [31:0] line_addr;
   } mem_req_t;

endpackage

// File: rtl/cache_mem_sram.sv
// Single-port backing store: synchronous read, per-byte write enable.
// The array is a plain unpacked memory so benches can preload it.
module cache_mem_sram #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned DEPTH  = 1024
) (
   input  logic                      clk,
   input  logic [$clog2(DEPTH)-1:0]  addr_i,
   input  logic                      re_i,
   input  logic [DATA_W/8-1:0]       we_i,
   input  logic [DATA_W-1:0]         wdata_i,
   output logic [DATA_W-1:0]         rdata_o
);

   localparam int unsigned SB = DATA_W / 8;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [DATA_W-1:0] rdata_q;

   always_ff @(posedge clk) begin
      for (int b = 0; b < SB; b++) begin
         if (we_i[b]) begin
            mem[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
         end
      end
      if (re_i) begin
         rdata_q <= mem[addr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/cache_mem_responder.sv
// Line-granular memory responder for the cache refill/writeback port:
// latency-delayed read bursts, strobed write bursts with a single ack.
module cache_mem_responder
   import cache_mem_pkg::*;
#(
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned BEATS   = 2 ** BEAT_IDX_W,
   parameter int unsigned DEPTH   = 1024,
   parameter int unsigned LATENCY = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic                req_we,
   input  logic [31:0]         req_addr,
   input  logic                wvalid,
   output logic                wready,
   input  logic [DATA_W-1:0]   wdata,
   input  logic [DATA_W/8-1:0] wstrb,
   output logic                resp_valid,
   input  logic                resp_ready,
   output logic [DATA_W-1:0]   resp_data,
   output logic                resp_last
);

   localparam int unsigned SB  = DATA_W / 8;
   localparam int unsigned WSH = $clog2(SB);
   localparam int unsigned AW  = $clog2(DEPTH);
   localparam int unsigned BW  = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int unsigned LW  = (LATENCY > 1) ? $clog2(LATENCY) : 1;

   state_e        state_q;
   mem_req_t      req_q;
   logic [BW-1:0] beat_q;
   logic [LW-1:0] lat_q;
   logic          rvld_q;

   logic [AW-1:0]     req_line;
   logic [AW-1:0]     line_w;
   logic [BW-1:0]     rd_beat;
   logic [AW-1:0]     sram_addr;
   logic              sram_re;
   logic [SB-1:0]     sram_we;
   logic [DATA_W-1:0] sram_rdata;
   logic              last_beat;
   logic              fire;
   logic              unused_bits;

   assign req_line  = AW'(req_addr >> WSH) & ~AW'(BEATS - 1);
   assign line_w    = req_q.line_addr[AW-1:0];
   assign last_beat = (beat_q == BW'(BEATS - 1));
   assign fire      = resp_valid && resp_ready;

   // Fetch the following beat on the handshake edge so bursts run gap-free.
   assign rd_beat   = (rvld_q && fire) ? beat_q + 1'b1 : beat_q;
   assign sram_addr = line_w + AW'((state_q == WBURST) ? beat_q : rd_beat);
   assign sram_re   = (state_q == RBURST);
   assign sram_we   = (state_q == WBURST && wvalid) ? wstrb : '0;

   assign req_ready  = (state_q == IDLE);
   assign wready     = (state_q == WBURST);
   assign resp_valid = (state_q == RBURST && rvld_q) || (state_q == WACK);
   assign resp_last  = (state_q == RBURST && rvld_q && last_beat)
                    || (state_q == WACK);
   assign resp_data  = (state_q == RBURST && rvld_q) ? sram_rdata : '0;

   assign unused_bits = ^{req_q.we, req_q.line_addr[31:AW]};

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         req_q   <= '0;
         beat_q  <= '0;
         lat_q   <= '0;
         rvld_q  <= 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (req_valid) begin
                  req_q.we        <= req_we;
                  req_q.line_addr <= 32'(req_line);
                  beat_q          <= '0;
                  lat_q           <= '0;
                  rvld_q          <= 1'b0;
                  if (req_we) begin
                     state_q <= WBURST;
                  end else if (LATENCY == 0) begin
                     state_q <= RBURST;
                  end else begin
                     state_q <= WAIT;
                  end
               end
            end
            WAIT: begin
               if (lat_q == LW'(LATENCY - 1)) begin
                  state_q <= RBURST;
               end else begin
                  lat_q <= lat_q + 1'b1;
               end
            end
            RBURST: begin
               if (!rvld_q) begin
                  rvld_q <= 1'b1;
               end else if (fire) begin
                  if (last_beat) begin
                     state_q <= IDLE;
                     rvld_q  <= 1'b0;
                  end else begin
                     beat_q <= beat_q + 1'b1;
                  end
               end
            end
            WBURST: begin
               if (wvalid) begin
                  if (last_beat) begin
                     state_q <= WACK;
                  end else begin
                     beat_q <= beat_q + 1'b1;
                  end
               end
            end
            WACK: begin
               if (resp_ready) begin
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   cache_mem_sram #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_sram (
      .clk     (clk),
      .addr_i  (sram_addr),
      .re_i    (sram_re),
      .we_i    (sram_we),
      .wdata_i (wdata),
      .rdata_o (sram_rdata)
   );

endmodule
